// File: rtl/light_fader.sv
// light_fader: brightness ramp generator feeding the PWM pulse_width input.
// A request latches a target duty and a step rate; pulse_width then walks
// one LSB per (rate * PRESCALE) clk cycles until it reaches the target.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; ready=1; same-value and rate=0 requests
//         | complete here without leaving IDLE
//   RAMP  | stepping pulse_width toward target_q; busy=1; start ignored
module light_fader #(
    parameter int PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] target,
    input  logic [7:0] rate,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] pulse_width
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [7:0]    tick_q;
    logic [7:0]    target_q;
    logic [7:0]    rate_q;
    logic [7:0]    pw_q;
    logic          done_q;

    logic          presc_wrap_d;
    logic          tick_wrap_d;
    logic          step_d;
    logic [7:0]    pw_step_d;

    // Tick/step decode and the one-LSB move toward the latched target.
    // rate_q is at least 1 whenever RAMP is active, so rate_q-1 never wraps there.
    always_comb begin
        presc_wrap_d = (presc_q == PRE_LAST);
        tick_wrap_d  = (tick_q == (rate_q - 8'd1));
        step_d       = presc_wrap_d && tick_wrap_d;
        pw_step_d    = (pw_q < target_q) ? (pw_q + 8'd1) : (pw_q - 8'd1);
    end

    // Control FSM with prescaler, tick counter and the registered duty output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            tick_q   <= '0;
            target_q <= '0;
            rate_q   <= '0;
            pw_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        target_q <= target;
                        rate_q   <= rate;
                        if (target == pw_q) begin
                            done_q <= 1'b1;
                        end else if (rate == 8'd0) begin
                            pw_q   <= target;
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RAMP;
                            presc_q <= '0;
                            tick_q  <= '0;
                        end
                    end
                end
                RAMP: begin
                    presc_q <= presc_wrap_d ? '0 : (presc_q + PW'(1));
                    if (presc_wrap_d) begin
                        tick_q <= tick_wrap_d ? 8'd0 : (tick_q + 8'd1);
                    end
                    if (step_d) begin
                        pw_q <= pw_step_d;
                        // Leaving RAMP on the landing edge makes the first cycle
                        // at the target show done=1 together with ready=1.
                        if (pw_step_d == target_q) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = (state_q == IDLE);
    assign busy        = (state_q == RAMP);
    assign done        = done_q;
    assign pulse_width = pw_q;

endmodule

// File: tb/tb_light_fader.sv
// tb_light_fader: scoreboard bench for light_fader with PRESCALE=4.
// Each accepted request pushes its expected pulse_width/done events
// (cycle, value, done) into a queue; a negedge monitor pops and compares
// one entry whenever the DUT changes pulse_width or raises done.
module tb_light_fader;

    localparam int PRE = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] target;
    logic [7:0] rate;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] pulse_width;

    light_fader #(.PRESCALE(PRE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .target     (target),
        .rate       (rate),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .pulse_width(pulse_width)
    );

    typedef struct {
        int         cyc;
        logic [7:0] pw;
        logic       dn;
    } ev_t;

    ev_t        sb[$];
    ev_t        mon_e;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       mon_en = 1'b0;
    logic [7:0] prev_pw = 8'd0;
    logic [7:0] model_pw = 8'd0;
    int         e0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every pulse_width change or done pulse must match the queue head.
    always @(negedge clk) begin
        if (mon_en && ((pulse_width !== prev_pw) || (done !== 1'b0))) begin
            if (sb.size() == 0) begin
                check_eq("spurious_event", {23'd0, done, pulse_width}, {24'd0, prev_pw});
            end else begin
                mon_e = sb.pop_front();
                check_eq("ev_cycle", cyc, mon_e.cyc);
                check_eq("ev_pw", {24'd0, pulse_width}, {24'd0, mon_e.pw});
                check_eq("ev_done", {31'd0, done}, {31'd0, mon_e.dn});
            end
        end
        prev_pw <= pulse_width;
    end

    // Step forward (post-edge) until the given edge count has been reached.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Predict the events of a request accepted at edge e_acc from model_pw.
    task automatic push_accept(input int e_acc, input logic [7:0] t, input logic [7:0] r);
        ev_t e;
        int  n;
        if (t == model_pw) begin
            e.cyc = e_acc; e.pw = t; e.dn = 1'b1;
            sb.push_back(e);
        end else if (r == 8'd0) begin
            e.cyc = e_acc; e.pw = t; e.dn = 1'b1;
            sb.push_back(e);
        end else begin
            n = (t > model_pw) ? int'(t) - int'(model_pw) : int'(model_pw) - int'(t);
            for (int k = 1; k <= n; k++) begin
                e.cyc = e_acc + k * int'(r) * PRE;
                e.pw  = (t > model_pw) ? model_pw + 8'(k) : model_pw - 8'(k);
                e.dn  = (k == n);
                sb.push_back(e);
            end
        end
        model_pw = t;
    endtask

    // Drive a request from a post-edge point; returns with e0 = accept edge.
    task automatic accept(input logic [7:0] t, input logic [7:0] r);
        start  = 1'b1;
        target = t;
        rate   = r;
        e0     = cyc + 1;
        push_accept(e0, t, r);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_queue", sb.size(), 0);
    endtask

    initial begin
        ev_t e;
        rst = 1'b1; start = 1'b0; target = 8'd0; rate = 8'd0;

        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pw", {24'd0, pulse_width}, 32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // 2 + 6a: 0 -> 3 at rate 2, with an ignored start mid-ramp
        accept(8'd3, 8'd2);
        check_eq("s2_busy_e0", {31'd0, busy}, 32'd1);
        check_eq("s2_ready_e0", {31'd0, ready}, 32'd0);
        goto(e0 + 9);
        start = 1'b1; target = 8'd50; rate = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("s6_busy_after_ign", {31'd0, busy}, 32'd1);
        goto(e0 + 24);
        check_eq("s2_pw_end", {24'd0, pulse_width}, 32'd3);
        check_eq("s2_done_end", {31'd0, done}, 32'd1);
        check_eq("s2_busy_end", {31'd0, busy}, 32'd0);
        check_eq("s2_ready_end", {31'd0, ready}, 32'd1);
        goto(e0 + 25);
        check_eq("s2_done_drop", {31'd0, done}, 32'd0);
        drain(50);

        // 3: 3 -> 0 at rate 1, no underflow
        accept(8'd0, 8'd1);
        goto(e0 + 12);
        check_eq("s3_pw_end", {24'd0, pulse_width}, 32'd0);
        check_eq("s3_done_end", {31'd0, done}, 32'd1);
        goto(e0 + 20);
        check_eq("s3_pw_hold", {24'd0, pulse_width}, 32'd0);
        check_eq("s3_busy_hold", {31'd0, busy}, 32'd0);
        drain(50);

        // 4: jump to 200 with rate 0
        accept(8'd200, 8'd0);
        check_eq("s4_pw", {24'd0, pulse_width}, 32'd200);
        check_eq("s4_done", {31'd0, done}, 32'd1);
        check_eq("s4_busy", {31'd0, busy}, 32'd0);
        goto(e0 + 1);
        check_eq("s4_done_drop", {31'd0, done}, 32'd0);
        drain(10);

        // 5: same-value request
        accept(8'd200, 8'd5);
        check_eq("s5_done", {31'd0, done}, 32'd1);
        check_eq("s5_pw", {24'd0, pulse_width}, 32'd200);
        for (int i = 0; i < 10; i++) begin
            check_eq("s5_busy", {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
        end
        drain(10);

        // back to 0 via reset
        rst = 1'b1;
        e.cyc = cyc + 1; e.pw = 8'd0; e.dn = 1'b0;
        sb.push_back(e);
        model_pw = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain(10);

        // 6b: reset in the middle of the 0 -> 3 ramp
        accept(8'd3, 8'd2);
        goto(e0 + 11);
        rst = 1'b1;
        sb.delete();
        e.cyc = e0 + 12; e.pw = 8'd0; e.dn = 1'b0;
        sb.push_back(e);
        model_pw = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("s6_rst_pw", {24'd0, pulse_width}, 32'd0);
        check_eq("s6_rst_ready", {31'd0, ready}, 32'd1);
        check_eq("s6_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("s6_rst_done", {31'd0, done}, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check_eq("s6_idle_pw", {24'd0, pulse_width}, 32'd0);
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/light_fader.md
Name: light_fader

Overview:
Brightness ramp generator that sits directly upstream of the PWM stage and drives its 8-bit pulse_width input. It accepts a target duty value and a step rate, then walks pulse_width one LSB at a time toward the target at a fixed, prescaled pace. The result is a smooth fade instead of an abrupt brightness jump.

Parameters:
PRESCALE, 1000, clk cycles per prescaler tick; legal range is 1 or greater, and 1 means a tick every cycle.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  load request; accepted only in a cycle where ready=1.
target  input  8  requested final pulse_width; sampled on accept.
rate  input  8  ticks per 1-LSB step; sampled on accept; 0 means jump immediately.
ready  output  1  high in IDLE; a new request can be accepted.
busy  output  1  high while ramping (RAMP state).
done  output  1  single-cycle pulse when pulse_width has reached the accepted target.
pulse_width  output  8  registered duty value fed to the PWM stage.

Behaviour:
- Reset, synchronous on rst=1 at a rising clk edge:
  - pulse_width=0, busy=0, done=0, ready=1, state=IDLE.
  - Prescaler and tick counter are cleared.
  - rst overrides all other inputs. A reset mid-ramp returns to these values at that same edge, and no done is issued.
- States: IDLE and RAMP. ready = (state==IDLE), busy = (state==RAMP); both are decoded from registered state.
- done defaults to 0 every cycle. When set, it is registered at an edge and is high for exactly one cycle.
- Accept edge E0 (IDLE with start=1): target_q<=target and rate_q<=rate, then exactly one of:
  - target == pulse_width: done=1 after E0; stay IDLE; pulse_width unchanged.
  - else if rate == 0: pulse_width<=target at E0 and done=1 after E0; stay IDLE.
  - else: state<=RAMP; prescaler and tick counter are cleared at E0.
- RAMP counters:
  - The prescaler counts 0..PRESCALE-1 and wraps. A tick is the edge where it wraps, so ticks fall at E0+PRESCALE, E0+2*PRESCALE, and so on.
  - The tick counter counts ticks 0..rate_q-1. On the rate_q-th tick it wraps and a step occurs.
- Step: pulse_width moves +1 if below target_q, or -1 if above. Step k therefore lands at edge E0 + k*rate_q*PRESCALE.
  - There is no overshoot, and there is no wrap-around at 0 or 255 because the target is always reached first.
- Completion: at the step edge where pulse_width becomes target_q, state<=IDLE and done<=1 at the same edge.
  - So the first cycle with pulse_width==target_q also has done=1, busy=0, and ready=1.
- Total ramp duration is |target_q - start value| * rate_q * PRESCALE cycles.
- start while in RAMP is ignored. The target, rate, and ramp continue unaffected.
- start and completion at the same edge: start is not accepted, because ready=0 during that cycle. It can be accepted from the next cycle.
- Changes to the target/rate inputs after accept have no effect, because the latched copies are used.
- Widths:
  - Prescaler is max(1, clog2(PRESCALE)) bits.
  - Tick counter is 8 bits.
  - The compare for the step is against rate_q-1, computed in 8 bits; this is valid because rate_q is at least 1 in RAMP.
- pulse_width changes only at step edges, accept edges (rate=0 case), or reset, so it is glitch-free for the downstream PWM.

Test Plan:
All scenarios run with PRESCALE=4.
1. Assert rst for 2 cycles -> pulse_width=0, ready=1, busy=0, done=0.
2. From 0: start, target=3, rate=2 at E0 -> busy=1 from E0; pulse_width=1 at E0+8, 2 at E0+16, 3 at E0+24. done=1 for exactly the cycle after E0+24, with busy=0 and ready=1 in that cycle.
3. From 3: start, target=0, rate=1 -> pulse_width=2, 1, 0 at E0+4, +8, +12; done pulses once; no underflow to 255.
4. start, target=200, rate=0 -> pulse_width=200 immediately after E0; done=1 for one cycle; busy stays 0.
5. From 200: start, target=200, rate=5 -> pulse_width unchanged; done=1 for one cycle after E0; busy never asserts.
6. During the ramp of scenario 2: pulse start with target=50 at E0+10 -> ignored, and the ramp still ends at 3 at E0+24. Separately, assert rst at E0+12 -> pulse_width=0, state=IDLE, done=0 after that edge.
